// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch controller for the 16-word program ROM. It owns the
//   4-bit PC and latches each ROM word into the instruction register. It then
//   offers the word to execute over a valid/ready handshake. jmp (1000) and
//   br (1100) are resolved here, so execute never writes the PC.
//
//   Optional feature macro: FETCH_STEP_EN
//     defined   -> PAUSE state is live. run/step gate fetching, and the block
//                  leaves reset paused.
//     undefined -> run/step are ignored, paused is tied 0, and the FSM loops
//                  FETCH -> ISSUE -> FETCH.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   run       in   level: 1 = free-running fetch (debug build only)
//   step      in   single-step request, edge-detected (debug build only)
//   rom_addr  out  ROM word address, always equal to pc
//   rom_data  in   ROM word, combinational from rom_addr
//   ir        out  latched instruction presented to decode
//   ir_valid  out  ir holds an instruction not yet accepted
//   ex_ready  in   execute accepts ir this cycle
//   zero      in   execute zero flag, used only when a br is accepted
//   pc        out  address of the instruction in ir / next fetch address
//   paused    out  FSM is in PAUSE
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ex_ready,
    input  logic        zero,
    output logic [3:0]  pc,
    output logic        paused
);

    typedef enum logic [1:0] {PAUSE, FETCH, ISSUE} state_t;

    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_BR  = 4'b1100;

    state_t     state;
    logic [3:0] next_pc;
    logic       accept;

    // ir_valid is only ever high in ISSUE, so this is the handshake edge.
    assign accept   = ir_valid & ex_ready;
    assign rom_addr = pc;

    // Redirect target comes straight from the held instruction. The target is
    // then fetched on the cycle right after accept, so there is no bubble.
    always_comb begin
        next_pc = pc + 4'd1;
        if (ir[15:12] == OP_JMP)
            next_pc = ir[11:8];
        else if (ir[15:12] == OP_BR && zero)
            next_pc = ir[11:8];
    end

`ifdef FETCH_STEP_EN
    localparam state_t RESET_STATE = PAUSE;
    logic step_q;
    logic resume;
    logic free_run;

    // Only a fresh 0->1 of step counts. A held step does not re-trigger, and
    // an edge seen outside PAUSE is dropped because step_q tracks every cycle.
    assign resume   = run | (step & ~step_q);
    assign free_run = run;
    assign paused   = (state == PAUSE);
`else
    localparam state_t RESET_STATE = FETCH;
    logic unused_dbg;
    logic free_run;

    assign unused_dbg = run ^ step;
    assign free_run   = 1'b1;
    assign paused     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_STATE;
            pc       <= 4'd0;
            ir       <= 16'h0000;
            ir_valid <= 1'b0;
`ifdef FETCH_STEP_EN
            step_q   <= 1'b0;
`endif
        end else begin
`ifdef FETCH_STEP_EN
            step_q <= step;
`endif
            case (state)
                FETCH: begin
                    ir       <= rom_data;
                    ir_valid <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (accept) begin
                        ir_valid <= 1'b0;
                        pc       <= next_pc;
                        state    <= free_run ? FETCH : PAUSE;
                    end
                end
`ifdef FETCH_STEP_EN
                PAUSE: begin
                    if (resume)
                        state <= FETCH;
                end
`endif
                default: state <= FETCH;
            endcase
        end
    end

endmodule
